data_mem_responder: RTL and testbench

Responder end of the processor's data-memory port: a single-ported word-addressed RAM that accepts the processor's combinational read/write requests, holds them off with `DataWaitreq` for a configurable number of wait states, then completes them in one handshake cycle. It sits between the pipelined core's Memory stage and on-chip block RAM. It also serves as the bench's behavioural data memory for exercising Memory-stage stalls.

---
 rtl/data_mem_responder.sv | 118 +++++++++++
 tb/tb_data_mem_responder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder: single-ported word RAM with a configurable wait-state handshake.
// Optional memory-mapped LED register when DMEM_MMIO_EN is defined.
module data_mem_responder #(
   parameter int WORD_SIZE   = 16,
   parameter int ADDR_BITS   = 8,
   parameter int WAIT_STATES = 1
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic [WORD_SIZE-1:0] DataAddr,
   input  logic [WORD_SIZE-1:0] DataOut,
   input  logic                 ReadData,
   input  logic                 WriteData,
   output logic [WORD_SIZE-1:0] DataIn,
   output logic                 DataWaitreq
`ifdef DMEM_MMIO_EN
   ,
   output logic [WORD_SIZE-1:0] LedOut
`endif
);

   localparam logic [3:0] WS = 4'(WAIT_STATES);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t               r_state, w_next;
   logic [3:0]           r_cnt, w_cnt_next;
   logic [WORD_SIZE-1:0] r_rdata;
   logic [WORD_SIZE-1:0] r_mem [0:(1<<ADDR_BITS)-1];
   logic                 w_req, w_capture, w_commit, w_mmio;
   logic [ADDR_BITS-1:0] w_idx;
   logic [WORD_SIZE-1:0] w_rd_src;

   assign w_req  = ReadData | WriteData;
   assign w_idx  = DataAddr[ADDR_BITS-1:0];
   assign DataIn = r_rdata;

`ifdef DMEM_MMIO_EN
   logic [WORD_SIZE-1:0] r_led;
   assign w_mmio   = (DataAddr[WORD_SIZE-1 -: 4] == 4'hF);
   assign w_rd_src = w_mmio ? r_led : r_mem[w_idx];
   assign LedOut   = r_led;
`else
   assign w_mmio   = 1'b0;
   assign w_rd_src = r_mem[w_idx];
`endif

   always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch behind.
      w_next      = r_state;
      w_cnt_next  = r_cnt;
      w_capture   = 1'b0;
      w_commit    = 1'b0;
      DataWaitreq = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            DataWaitreq = w_req;
            if (w_req) begin
               w_cnt_next = WS;
               if (WS == 4'd0) begin
                  w_capture = ReadData;
                  w_next    = S_DONE;
               end else begin
                  w_next = S_BUSY;
               end
            end
         end
         S_BUSY: begin
            if (!w_req) begin
               w_next = S_IDLE;
            end else begin
               DataWaitreq = 1'b1;
               w_cnt_next  = 4'(r_cnt - 4'd1);
               if (r_cnt == 4'd1) begin
                  w_capture = ReadData;
                  w_next    = S_DONE;
               end
            end
         end
         S_DONE: begin
            w_commit = WriteData;
            w_next   = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
      // A synchronous reset in DONE must also drop the pending write.
      if (Reset) begin
         DataWaitreq = 1'b0;
         w_commit    = 1'b0;
      end
   end

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_rdata <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_next;
         if (w_capture) r_rdata <= w_rd_src;
      end
   end

   // NOTE: the RAM array has no reset so it maps onto block RAM; contents start undefined.
   always_ff @(posedge Clock) begin
      if (w_commit && !w_mmio) r_mem[w_idx] <= DataOut;
   end

`ifdef DMEM_MMIO_EN
   always_ff @(posedge Clock) begin
      if (Reset)                r_led <= '0;
      else if (w_commit && w_mmio) r_led <= DataOut;
   end
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: three instances with WAIT_STATES 0, 1 and 3.
// Define DMEM_MMIO_EN on both files to include the LED register checks.
module tb_data_mem_responder;

   logic        clk = 1'b0;
   logic        rst   [3];
   logic [15:0] addr  [3];
   logic [15:0] wd    [3];
   logic        re    [3];
   logic        we    [3];
   logic [15:0] din   [3];
   logic        wreq  [3];
   logic [15:0] led   [3];
   int          ws_of [3] = '{0, 1, 3};
   int          cyc = 0;
   int          n_vec = 0;
   int          n_miss = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      data_mem_responder #(
         .WORD_SIZE  (16),
         .ADDR_BITS  (8),
         .WAIT_STATES(g == 0 ? 0 : (g == 1 ? 1 : 3))
      ) u_dut (
         .Clock      (clk),
         .Reset      (rst[g]),
         .DataAddr   (addr[g]),
         .DataOut    (wd[g]),
         .ReadData   (re[g]),
         .WriteData  (we[g]),
         .DataIn     (din[g]),
         .DataWaitreq(wreq[g])
`ifdef DMEM_MMIO_EN
         ,
         .LedOut     (led[g])
`endif
      );
   end

`ifndef DMEM_MMIO_EN
   initial for (int i = 0; i < 3; i++) led[i] = '0;
`endif

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Starts just after a rising edge; returns just after the completion cycle's rising edge.
   task automatic do_access(input int k, input logic w, input logic r,
                            input logic [15:0] a, input logic [15:0] d,
                            output int nwait, output logic [15:0] rd);
      nwait   = 0;
      addr[k] = a;
      wd[k]   = d;
      we[k]   = w;
      re[k]   = r;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (wreq[k]) nwait++;
         else break;
      end
      rd = din[k];
      @(posedge clk);
      #1;
      we[k] = 1'b0;
      re[k] = 1'b0;
   endtask

   typedef struct {
      int          k;
      logic        w;
      logic        r;
      logic [15:0] a;
      logic [15:0] d;
      logic [15:0] exp;
   } vec_t;

   vec_t        tbl [12];
   logic [15:0] last_rd [3];
   logic [15:0] rd, exp_rd;
   int          nw, c0;

   initial begin
      tbl[0]  = '{1, 1'b1, 1'b0, 16'h0005, 16'h1234, 16'h0000};
      tbl[1]  = '{1, 1'b0, 1'b1, 16'h0005, 16'h0000, 16'h1234};
      tbl[2]  = '{1, 1'b1, 1'b0, 16'h0107, 16'h00AA, 16'h0000};
      tbl[3]  = '{1, 1'b0, 1'b1, 16'h0007, 16'h0000, 16'h00AA};
      tbl[4]  = '{1, 1'b1, 1'b0, 16'h0020, 16'hCAFE, 16'h0000};
      tbl[5]  = '{1, 1'b1, 1'b1, 16'h0020, 16'h0BAD, 16'hCAFE};
      tbl[6]  = '{1, 1'b0, 1'b1, 16'h0020, 16'h0000, 16'h0BAD};
      tbl[7]  = '{0, 1'b1, 1'b0, 16'h0010, 16'h0F0F, 16'h0000};
      tbl[8]  = '{0, 1'b0, 1'b1, 16'h0010, 16'h0000, 16'h0F0F};
      tbl[9]  = '{2, 1'b1, 1'b0, 16'h0040, 16'h1357, 16'h0000};
      tbl[10] = '{2, 1'b0, 1'b1, 16'h0040, 16'h0000, 16'h1357};
      tbl[11] = '{1, 1'b1, 1'b0, 16'h0011, 16'h4444, 16'h0000};

      for (int i = 0; i < 3; i++) begin
         rst[i] = 1'b1; re[i] = 1'b0; we[i] = 1'b0;
         addr[i] = '0; wd[i] = '0; last_rd[i] = '0;
      end

      // Reset: requests present, stall must stay low; DataIn clears.
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) re[i] = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 3; i++) check($sformatf("rst_waitreq%0d", i), wreq[i], 1'b0);
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin rst[i] = 1'b0; re[i] = 1'b0; end
      @(negedge clk);
      for (int i = 0; i < 3; i++) check($sformatf("rst_datain%0d", i), din[i], 16'h0000);
      @(posedge clk); #1;

      for (int i = 0; i < 12; i++) begin
         do_access(tbl[i].k, tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d, nw, rd);
         check($sformatf("v%0d_waits", i), nw, ws_of[tbl[i].k] + 1);
         exp_rd = tbl[i].r ? tbl[i].exp : last_rd[tbl[i].k];
         check($sformatf("v%0d_datain", i), rd, exp_rd);
         if (tbl[i].r) last_rd[tbl[i].k] = tbl[i].exp;
      end

      // WAIT_STATES=0 back-to-back write then read: 1,0,1,0 in four cycles.
      c0 = cyc;
      do_access(0, 1'b1, 1'b0, 16'h0003, 16'hBEEF, nw, rd);
      check("b2b_w_waits", nw, 1);
      do_access(0, 1'b0, 1'b1, 16'h0003, 16'h0000, nw, rd);
      check("b2b_r_waits", nw, 1);
      check("b2b_datain", rd, 16'hBEEF);
      check("b2b_cycles", cyc - c0, 4);

      // Abort with WAIT_STATES=3: drop the write after two stalled cycles.
      do_access(2, 1'b1, 1'b0, 16'h0009, 16'h1111, nw, rd);
      do_access(2, 1'b0, 1'b1, 16'h0009, 16'h0000, nw, rd);
      check("abort_pre_rd", rd, 16'h1111);
      addr[2] = 16'h0009; wd[2] = 16'h5555; we[2] = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         check($sformatf("abort_stall%0d", c), wreq[2], 1'b1);
         @(posedge clk); #1;
      end
      we[2] = 1'b0;
      @(negedge clk);
      check("abort_waitreq", wreq[2], 1'b0);
      check("abort_datain", din[2], 16'h1111);
      @(posedge clk); #1;
      do_access(2, 1'b0, 1'b1, 16'h0009, 16'h0000, nw, rd);
      check("abort_rd_waits", nw, 4);
      check("abort_rd", rd, 16'h1111);

      // Reset asserted in BUSY of a write: write is dropped, DataIn clears.
      do_access(1, 1'b1, 1'b0, 16'h0002, 16'h2222, nw, rd);
      do_access(1, 1'b0, 1'b1, 16'h0002, 16'h0000, nw, rd);
      check("rstmid_pre_rd", rd, 16'h2222);
      addr[1] = 16'h0002; wd[1] = 16'h7777; we[1] = 1'b1;
      @(posedge clk); #1;
      rst[1] = 1'b1;
      @(negedge clk);
      check("rstmid_waitreq", wreq[1], 1'b0);
      @(posedge clk); #1;
      rst[1] = 1'b0; we[1] = 1'b0;
      @(negedge clk);
      check("rstmid_datain", din[1], 16'h0000);
      @(posedge clk); #1;
      do_access(1, 1'b0, 1'b1, 16'h0002, 16'h0000, nw, rd);
      check("rstmid_rd_waits", nw, 2);
      check("rstmid_rd", rd, 16'h2222);

`ifdef DMEM_MMIO_EN
      // LED register at the top of the address map; RAM index 0 untouched.
      do_access(1, 1'b1, 1'b0, 16'h0000, 16'h0ABC, nw, rd);
      do_access(1, 1'b1, 1'b0, 16'hF000, 16'h00F0, nw, rd);
      check("mmio_w_waits", nw, 2);
      check("mmio_led", led[1], 16'h00F0);
      do_access(1, 1'b0, 1'b1, 16'hF000, 16'h0000, nw, rd);
      check("mmio_rd", rd, 16'h00F0);
      do_access(1, 1'b0, 1'b1, 16'h0000, 16'h0000, nw, rd);
      check("mmio_ram0", rd, 16'h0ABC);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
